// File: rtl/tl_pkg.sv
// Shared constants for the taillight input conditioner: channel count,
// channel index map and the per-channel vector type.
package tl_pkg;

    localparam int NUM_CH     = 5;

    localparam int CH_LEFT    = 0;
    localparam int CH_RIGHT   = 1;
    localparam int CH_BRAKE   = 2;
    localparam int CH_HAZARD  = 3;
    localparam int CH_RUN     = 4;

    // One bit per channel, indexed by the CH_* constants above.
    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage : tl_pkg

// File: rtl/input_conditioner_if.sv
// Raw switch levels in, conditioned levels plus change strobe out.
// master drives the raw switches and observes the results; slave is the conditioner.
interface input_conditioner_if;

    logic left_in;
    logic right_in;
    logic brake_in;
    logic hazard_in;
    logic runlight_in;

    logic left;
    logic right;
    logic brake;
    logic hazard;
    logic runlight;
    logic changed;

    modport master (
        output left_in, right_in, brake_in, hazard_in, runlight_in,
        input  left, right, brake, hazard, runlight, changed
    );

    modport slave (
        input  left_in, right_in, brake_in, hazard_in, runlight_in,
        output left, right, brake, hazard, runlight, changed
    );

endinterface : input_conditioner_if

// File: rtl/debounce_ch.sv
// One conditioning channel: 2-flop synchronizer, stability counter and
// output flop. The output only moves once the synchronized level has
// disagreed with it for DEBOUNCE_CYCLES consecutive edges.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] count;
    logic          hit;

    // The edge on which the counter would reach DEBOUNCE_CYCLES is the edge
    // that commits s2 to the output, so the stored count never exceeds N-1.
    assign hit  = (s2 != level) && (count == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = hit && s2;

    // Synchronize, then count disagreeing edges and commit on reaching the threshold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            count <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                count <= '0;
            end else if (hit) begin
                count <= '0;
                level <= s2;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule : debounce_ch

// File: rtl/input_conditioner.sv
// Conditions the five raw taillight switch inputs and raises a single-cycle
// 'changed' strobe the cycle after any conditioned output moves.
// Build option HAZARD_TOGGLE_EN: hazard becomes a push-on/push-off latch
// toggled by each debounced press; otherwise it is the debounced level.
module input_conditioner
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input_conditioner_if.slave   io
);

    ch_vec_t raw_vec;
    ch_vec_t level_vec;
    ch_vec_t rise_vec;
    ch_vec_t out_vec;
    ch_vec_t prev_vec;
    logic    changed_q;

    assign raw_vec[CH_LEFT]   = io.left_in;
    assign raw_vec[CH_RIGHT]  = io.right_in;
    assign raw_vec[CH_BRAKE]  = io.brake_in;
    assign raw_vec[CH_HAZARD] = io.hazard_in;
    assign raw_vec[CH_RUN]    = io.runlight_in;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_vec[i]),
            .level (level_vec[i]),
            .rise  (rise_vec[i])
        );
    end

`ifdef HAZARD_TOGGLE_EN
    logic hazard_q;

    // Flip the hazard latch on each debounced press; releases are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hazard_q <= 1'b0;
        end else if (rise_vec[CH_HAZARD]) begin
            hazard_q <= ~hazard_q;
        end
    end

    always_comb begin
        out_vec            = level_vec;
        out_vec[CH_HAZARD] = hazard_q;
    end
`else
    logic unused_rise;
    assign unused_rise = ^rise_vec;
    assign out_vec     = level_vec;
`endif

    // Remember the last output word and pulse once when it differs; reset
    // clears both, so leaving reset cannot produce a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_vec  <= '0;
            changed_q <= 1'b0;
        end else begin
            prev_vec  <= out_vec;
            changed_q <= (out_vec != prev_vec);
        end
    end

    assign io.left     = out_vec[CH_LEFT];
    assign io.right    = out_vec[CH_RIGHT];
    assign io.brake    = out_vec[CH_BRAKE];
    assign io.hazard   = out_vec[CH_HAZARD];
    assign io.runlight = out_vec[CH_RUN];
    assign io.changed  = changed_q;

endmodule : input_conditioner

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive stable cycles required before an output changes (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all state SHALL be clocked on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have ports left_in, right_in, brake_in, hazard_in and runlight_in, each an input of 1 bit: raw, asynchronous, bouncing switch levels.
REQ-005 The module SHALL have ports left, right, brake, hazard and runlight, each an output of 1 bit: conditioned levels that drive the taillight controller inputs of the same names.
REQ-006 The module SHALL have port changed, output, 1 bit: a one-cycle strobe asserted in the cycle after any conditioned output changes.

Function
REQ-007 Each raw input SHALL pass through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-008 Each channel SHALL hold a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-009 The counter SHALL reset to 0 on any edge where s2 equals the channel output.
REQ-010 On any edge where s2 differs from the channel output, the counter SHALL increment.
REQ-011 When the counter reaches DEBOUNCE_CYCLES, the output SHALL take the value of s2 on that same edge, and the counter SHALL return to 0.
REQ-012 Latency: a raw level stable before rising edge k and held SHALL appear on the output after edge k+DEBOUNCE_CYCLES+1.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-014 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each complete on their own schedule.
REQ-015 The conditioner SHALL pass left and right high together unmodified; it SHALL NOT resolve conflicts.
REQ-016 changed SHALL be asserted for exactly one cycle, on the edge after any output bit differs from its prior value.
REQ-017 Simultaneous changes on several channels SHALL produce a single changed pulse.
REQ-018 The counter SHALL saturate logic-wise and SHALL NOT wrap, since it is cleared on match.

Reset
REQ-019 While rst=0, all synchronizer flops, counters, outputs and changed SHALL be 0, asynchronously and without waiting for clk.
REQ-020 When rst deasserts mid-bounce, conditioning SHALL restart from the all-zero state, with the full latency of REQ-012.
REQ-021 Reset deassertion SHALL itself generate no changed pulse.

Configuration
REQ-022 With macro HAZARD_TOGGLE_EN defined, the hazard output SHALL be a latch that toggles on each debounced 0->1 transition of hazard_in, and debounced 1->0 transitions SHALL be ignored.
REQ-023 Without HAZARD_TOGGLE_EN, hazard SHALL be the debounced level, like the other channels.
REQ-024 The hazard latch SHALL reset to 0.

Structure
REQ-025 Shared package tl_pkg SHALL hold NUM_CH=5 and the channel index constants CH_LEFT=0, CH_RIGHT=1, CH_BRAKE=2, CH_HAZARD=3 and CH_RUN=4.
REQ-026 Sub-module debounce_ch (synchronizer plus counter plus output flop, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated NUM_CH times.
REQ-027 The hazard toggle and the changed logic SHALL live in the top level.

Verification (DEBOUNCE_CYCLES=4, 10-unit clk period)
REQ-028 Reset and steady input: assert rst=0 with all inputs 1 -> all outputs 0 immediately; release rst and hold inputs -> all outputs 1 exactly 5 edges later, with a single changed pulse.
REQ-029 Bounce: left_in toggles 1,0,1,0 for one cycle each, then holds 1 -> left stays 0 through the bounce and rises 5 edges after the final stable 1; right is unaffected.
REQ-030 Glitch rejection: brake_in high for 3 cycles, then low -> brake remains 0 and changed is never asserted.
REQ-031 Simultaneous events: left_in and right_in both rise before the same edge -> both outputs rise on the same edge and changed pulses once; one cycle later changed=0.
REQ-032 Hazard toggle: with HAZARD_TOGGLE_EN, two stable presses of hazard_in (each high 8 cycles, low 8 cycles) -> hazard goes 1 after the first press and 0 after the second; without the macro, hazard follows the level each time.
REQ-033 Reset mid-operation: assert rst=0 while the counter is at 3 -> outputs remain 0; after release the full 5-edge latency is required again.
